// File: rtl/scaled_seq_mult_pkg.sv
// Shared constants and types for the scaled-word arithmetic stages (multiplier, add/sub).
// A scaled word is {S, M}: M is a two's-complement mantissa and the value is M * 2^-S.
package scaled_seq_mult_pkg;

  localparam int SCALE_W = 3;
  localparam int MANT_W  = 13;
  localparam int WORD_W  = SCALE_W + MANT_W;
  localparam int PROD_W  = 2 * MANT_W - 1;
  localparam int CNT_W   = 4;

  localparam logic [SCALE_W:0]   SMAX     = (SCALE_W + 1)'((1 << SCALE_W) - 1);
  localparam logic [MANT_W-1:0]  MANT_MAX = {1'b0, {(MANT_W - 1){1'b1}}};
  localparam logic [MANT_W-1:0]  MANT_MIN = {1'b1, {(MANT_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_NORM = 2'd2
  } state_t;

  // The most negative mantissa maps to 2^(MANT_W-1), which is still representable unsigned.
  function automatic logic [MANT_W-1:0] mant_mag(input logic [MANT_W-1:0] m);
    return m[MANT_W-1] ? -m : m;
  endfunction

endpackage

// File: rtl/scaled_seq_mult_if.sv
// Request/result bundle for the scaled multiplier: start plus operands in, status plus result out.
interface scaled_seq_mult_if import scaled_seq_mult_pkg::*; ();

  logic              start;
  logic [WORD_W-1:0] in1;
  logic [WORD_W-1:0] in2;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] out;
  logic              invalid;

  modport master (
    output start, in1, in2,
    input  busy, done, out, invalid
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, out, invalid
  );

endinterface

// File: rtl/seq_mag_mult_13.sv
// Unsigned 13x13 shift-add multiplier: one multiplier bit per step, LSB first.
// o_last flags the step that completes the product.
module seq_mag_mult_13 import scaled_seq_mult_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [MANT_W-1:0] i_mcand,
  input  logic [MANT_W-1:0] i_mplier,
  output logic [PROD_W-1:0] o_prod,
  output logic              o_last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MANT_W - 1);

  logic [PROD_W-1:0] r_mcand;
  logic [PROD_W-1:0] r_prod;
  logic [MANT_W-1:0] r_mplier;
  logic [CNT_W-1:0]  r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= PROD_W'(i_mcand);
      r_mplier <= i_mplier;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (i_step) begin
      if (r_mplier[0]) begin
        r_prod <= r_prod + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  assign o_prod = r_prod;
  assign o_last = i_step && (r_cnt == LAST_CNT);

endmodule

// File: rtl/scaled_seq_mult.sv
// Signed scaled-word multiplier: magnitude shift-add core, then renormalise one bit per cycle
// until the scale is in range and the mantissa fits, saturating at scale 0.
module scaled_seq_mult import scaled_seq_mult_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  scaled_seq_mult_if.slave   bus
);

  localparam logic [PROD_W-1:0] P_MAX     = PROD_W'(MANT_MAX);
  localparam logic [PROD_W-1:0] P_NEG_MAX = P_MAX + PROD_W'(1);

  state_t            r_state;
  logic              r_neg;
  logic [SCALE_W:0]  r_scale;
  logic [CNT_W-1:0]  r_shift;
  logic              r_busy;
  logic              r_done;
  logic              r_invalid;
  logic [WORD_W-1:0] r_out;

  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic              w_fit;
  logic              w_shift;
  logic [MANT_W-1:0] w_mag_a;
  logic [MANT_W-1:0] w_mag_b;
  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] w_p;
  logic [MANT_W-1:0] w_mr;

  assign w_load  = (r_state == ST_IDLE) && bus.start;
  assign w_step  = (r_state == ST_MULT);
  assign w_mag_a = mant_mag(bus.in1[MANT_W-1:0]);
  assign w_mag_b = mant_mag(bus.in2[MANT_W-1:0]);

  seq_mag_mult_13 u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_mcand  (w_mag_a),
    .i_mplier (w_mag_b),
    .o_prod   (w_prod),
    .o_last   (w_last)
  );

  // Repeated truncating halving of a non-negative product equals one shift by the count.
  assign w_p     = w_prod >> r_shift;
  assign w_fit   = (w_p <= P_MAX) || (r_neg && (w_p == P_NEG_MAX));
  assign w_shift = (r_scale > SMAX) || (!w_fit && (r_scale != '0));
  assign w_mr    = r_neg ? -w_p[MANT_W-1:0] : w_p[MANT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_neg     <= 1'b0;
      r_scale   <= '0;
      r_shift   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_invalid <= 1'b0;
      r_out     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_neg   <= bus.in1[MANT_W-1] ^ bus.in2[MANT_W-1];
            r_scale <= {1'b0, bus.in1[WORD_W-1:MANT_W]} + {1'b0, bus.in2[WORD_W-1:MANT_W]};
            r_shift <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_MULT;
          end
        end
        ST_MULT: begin
          if (w_last) begin
            r_state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (w_shift) begin
            r_scale <= r_scale - (SCALE_W + 1)'(1);
            r_shift <= r_shift + CNT_W'(1);
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
            if (w_fit) begin
              r_out     <= {r_scale[SCALE_W-1:0], w_mr};
              r_invalid <= 1'b0;
            end else begin
              r_out     <= {SCALE_W'(0), r_neg ? MANT_MIN : MANT_MAX};
              r_invalid <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.out     = r_out;
  assign bus.invalid = r_invalid;

endmodule
